// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline stall/flush/freeze sequencer (optional perf counters via HAZARD_PERF_CNT_EN)
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             startin,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_rt,
    input  logic             MEM_branch,
    input  logic             MEM_zero,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             pc_src,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             pipe_hold,
    output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, FREEZE = 2'd2} state_t;
    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
    state_t     r_state, w_next;
    logic [3:0] r_init_cnt;
    logic       w_branch, w_load_use;
    assign w_branch   = MEM_branch & MEM_zero;
    assign w_load_use = EX_mem_read && (EX_rt != 5'd0) &&
                        ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
    assign ctrl_state = r_state;
    // State register and init counter; the counter only runs while in INIT
    always_ff @(posedge clk) begin
        if (startin) begin
            r_state    <= INIT;
            r_init_cnt <= 4'd0;
        end else begin
            r_state    <= w_next;
            r_init_cnt <= (r_state == INIT) ? r_init_cnt + 4'd1 : 4'd0;
        end
    end
    // Next state and stage-register controls; startin forces the INIT controls
    always_comb begin
        w_next       = r_state;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        pipe_hold    = 1'b0;
        case (r_state)
            RUN: begin
                if (mem_busy) begin
                    w_next    = FREEZE;
                    pipe_hold = 1'b1;
                end else if (w_branch) begin
                    pc_src       = 1'b1;
                    pc_write     = 1'b1;
                    IF_ID_write  = 1'b1;
                    IF_ID_flush  = 1'b1;
                    ID_EX_flush  = 1'b1;
                    EX_MEM_flush = 1'b1;
                end else if (w_load_use) begin
                    ID_EX_flush = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    IF_ID_write = 1'b1;
                end
            end
            FREEZE: begin
                pipe_hold = 1'b1;
                w_next    = mem_busy ? FREEZE : RUN;
            end
            default: begin
                w_next       = (r_state == INIT && r_init_cnt == INIT_LAST) ? RUN : INIT;
                IF_ID_flush  = 1'b1;
                ID_EX_flush  = 1'b1;
                EX_MEM_flush = 1'b1;
            end
        endcase
        if (startin) begin
            pc_write     = 1'b0;
            pc_src       = 1'b0;
            IF_ID_write  = 1'b0;
            pipe_hold    = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_run_free;
    assign w_run_free = (r_state == RUN) && !mem_busy;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    // Saturating counters of load-use stalls and taken-branch flushes in RUN
    always_ff @(posedge clk) begin
        if (startin) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_run_free && !w_branch && w_load_use && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_run_free && w_branch && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven directed check of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        startin = 1'b1;
    logic [4:0]  ID_rs = '0, ID_rt = '0, EX_rt = '0;
    logic        ID_uses_rt = 1'b0, EX_mem_read = 1'b0, MEM_branch = 1'b0, MEM_zero = 1'b0, mem_busy = 1'b0;
    logic        pc_write, pc_src, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold;
    logic [1:0]  ctrl_state;
    logic [6:0]  outs;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif
    assign outs = {pc_write, pc_src, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold};

    pipeline_hazard_ctrl #(.INIT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .startin(startin), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .MEM_branch(MEM_branch), .MEM_zero(MEM_zero),
        .mem_busy(mem_busy), .pc_write(pc_write), .pc_src(pc_src), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
        .pipe_hold(pipe_hold), .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {pc_write, pc_src, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold}
    localparam logic [6:0] O_INIT  = 7'b0001110;
    localparam logic [6:0] O_NORM  = 7'b1010000;
    localparam logic [6:0] O_STALL = 7'b0000100;
    localparam logic [6:0] O_BR    = 7'b1111110;
    localparam logic [6:0] O_HOLD  = 7'b0000001;

    typedef struct {
        logic       st;
        logic [4:0] rs, rt;
        logic       uses, mr;
        logic [4:0] ert;
        logic       br, z, busy;
        logic [6:0] eo;
        logic [1:0] es;
        logic       cs;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0, n_err = 0, rst_idx = 0;

    task automatic add(input logic st, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] ert, input logic br, input logic z,
                       input logic busy, input logic [6:0] eo, input logic [1:0] es, input logic cs);
        vec_t v;
        v.st = st; v.rs = rs; v.rt = rt; v.uses = uses; v.mr = mr; v.ert = ert;
        v.br = br; v.z = z; v.busy = busy; v.eo = eo; v.es = es; v.cs = cs;
        tbl.push_back(v);
    endtask

    initial begin
        // four INIT cycles after release, then RUN
        repeat (4) add(0, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 2'd0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd1, 1);
        // load-use on rs, one stall, then clear
        add(0, 5, 0, 0, 1, 5, 0, 0, 0, O_STALL, 2'd1, 1);
        add(0, 5, 0, 0, 0, 5, 0, 0, 0, O_NORM, 2'd1, 1);
        // load to $zero never stalls
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, O_NORM, 2'd1, 1);
        // rt match only counts when ID reads rt; persisting hazard keeps stalling
        add(0, 3, 8, 0, 1, 8, 0, 0, 0, O_NORM, 2'd1, 1);
        add(0, 3, 8, 1, 1, 8, 0, 0, 0, O_STALL, 2'd1, 1);
        add(0, 3, 8, 1, 1, 8, 0, 0, 0, O_STALL, 2'd1, 1);
        // taken branch overrides load-use; untaken branch is normal
        add(0, 5, 0, 0, 1, 5, 1, 1, 0, O_BR, 2'd1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, O_NORM, 2'd1, 1);
        // busy 3 cycles with a branch pending, release cycle still holds, then branch acts
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, O_HOLD, 2'd1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, O_HOLD, 2'd2, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, O_HOLD, 2'd2, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, O_HOLD, 2'd2, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, O_BR, 2'd1, 1);
        // busy masks a load-use, which is then taken after the freeze
        add(0, 7, 0, 0, 1, 7, 0, 0, 1, O_HOLD, 2'd1, 1);
        add(0, 7, 0, 0, 1, 7, 0, 0, 0, O_HOLD, 2'd2, 1);
        add(0, 7, 0, 0, 1, 7, 0, 0, 0, O_STALL, 2'd1, 1);
        // enter FREEZE, then pulse startin mid-freeze
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd2, 1);
        rst_idx = tbl.size();
        add(1, 7, 0, 0, 1, 7, 1, 1, 1, O_INIT, 2'd0, 0);
        repeat (4) add(0, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 2'd0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd1, 1);

        // hand-written reset: outputs forced to INIT while startin is high
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (outs !== O_INIT || ctrl_state !== 2'd0) begin
                n_err++;
                $display("FAIL reset outs=%b state=%0d expected outs=%b state=0", outs, ctrl_state, O_INIT);
            end
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            startin = tbl[i].st; ID_rs = tbl[i].rs; ID_rt = tbl[i].rt; ID_uses_rt = tbl[i].uses;
            EX_mem_read = tbl[i].mr; EX_rt = tbl[i].ert; MEM_branch = tbl[i].br;
            MEM_zero = tbl[i].z; mem_busy = tbl[i].busy;
            @(negedge clk);
            n_vec++;
            if (outs !== tbl[i].eo || (tbl[i].cs && ctrl_state !== tbl[i].es)) begin
                n_err++;
                $display("FAIL vec%0d outs=%b state=%0d expected outs=%b state=%0d",
                         i, outs, ctrl_state, tbl[i].eo, tbl[i].es);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (i == rst_idx || i == rst_idx + 1) begin
                n_vec++;
                if (i == rst_idx ? (stall_cnt !== 16'd4 || flush_cnt !== 16'd2)
                                 : (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)) begin
                    n_err++;
                    $display("FAIL perf_cnt vec%0d stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             i, stall_cnt, flush_cnt, (i == rst_idx) ? 4 : 0, (i == rst_idx) ? 2 : 0);
                end
            end
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
